// File: rtl/wb_pic.sv
// Wishbone 8-input priority interrupt controller with 2-flop irq synchronizers and an inta_i vector FSM.
// Optional build macro PIC_AUTO_EOI_EN: clear the acknowledged ISR bit when inta_i falls.
module wb_pic #(
  parameter logic [7:0] VEC_BASE = 8'h08
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_adr_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic [7:0]  irq_i,
  output logic        intr_o,
  input  logic        inta_i,
  output logic [7:0]  vec_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    HOLD  = 2'd2
  } ack_state_e;

  ack_state_e state, state_nxt;

  logic [7:0]  irq_s1, irq_s2, irq_q;
  logic [7:0]  irr, isr, imr, ack_bit;
  logic [7:0]  irr_nxt, isr_nxt, vec_nxt, ack_bit_nxt;
  logic [7:0]  irq_rise, pending, ack_mask, eoi_mask, release_mask;
  logic [2:0]  ack_idx;
  logic        inta_q, inta_rise, do_ack, do_release;
  logic        bus_busy, ack_set, reg_wr, eoi, imr_wr, intr_nxt, blocked;
  logic [15:0] rd_data;
  logic        unused_ok;

  // Isolates the lowest-index (highest-priority) set bit.
  function automatic logic [7:0] lowest(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  assign unused_ok = ^{wb_sel_i[1], wb_dat_i[15:8]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    irq_rise  = irq_s2 & ~irq_q;
    inta_rise = inta_i & ~inta_q;
    pending   = irr & ~imr;

    ack_set = wb_stb_i & wb_cyc_i & ~bus_busy;
    reg_wr  = ack_set & wb_we_i & wb_sel_i[0];
    eoi     = reg_wr & ~wb_adr_i & wb_dat_i[5];
    imr_wr  = reg_wr & wb_adr_i;
    rd_data = wb_adr_i ? {8'h00, imr} : {isr, irr};

    state_nxt  = state;
    do_ack     = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        if (inta_rise) begin
          state_nxt = LATCH;
          do_ack    = 1'b1;
        end
      end
      LATCH: begin
        state_nxt  = inta_i ? HOLD : IDLE;
        do_release = ~inta_i;
      end
      HOLD: begin
        if (!inta_i) begin
          state_nxt  = IDLE;
          do_release = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    ack_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) ack_idx = 3'(i);
    end
    ack_mask = do_ack ? lowest(pending) : 8'h00;
    eoi_mask = eoi ? lowest(isr) : 8'h00;
`ifdef PIC_AUTO_EOI_EN
    release_mask = do_release ? ack_bit : 8'h00;
`else
    release_mask = 8'h00;
`endif

    // EOI works on the pre-acknowledge ISR; a new edge wins over an acknowledge clear.
    isr_nxt     = (isr & ~eoi_mask & ~release_mask) | ack_mask;
    irr_nxt     = (irr & ~ack_mask) | irq_rise;
    ack_bit_nxt = do_ack ? ack_mask : ack_bit;

    vec_nxt = vec_o;
    if (do_ack) begin
      vec_nxt = (pending != 8'h00) ? VEC_BASE + {5'd0, ack_idx} : VEC_BASE + 8'd7;
    end else if (do_release) begin
      vec_nxt = 8'h00;
    end

    // A request is blocked by any in-service bit at the same or higher priority.
    intr_nxt = 1'b0;
    blocked  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      blocked = blocked | isr[n];
      if (pending[n] && !blocked) intr_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_s1   <= 8'h00;
      irq_s2   <= 8'h00;
      irq_q    <= 8'h00;
      irr      <= 8'h00;
      isr      <= 8'h00;
      imr      <= 8'hFF;
      ack_bit  <= 8'h00;
      intr_o   <= 1'b0;
      wb_ack_o <= 1'b0;
      bus_busy <= 1'b0;
      wb_dat_o <= 16'h0000;
      vec_o    <= 8'h00;
      // Starts high so an inta_i still asserted across reset is not taken as a new edge.
      inta_q   <= 1'b1;
      state    <= IDLE;
    end else begin
      irq_s1   <= irq_i;
      irq_s2   <= irq_s1;
      irq_q    <= irq_s2;
      irr      <= irr_nxt;
      isr      <= isr_nxt;
      if (imr_wr) imr <= wb_dat_i[7:0];
      ack_bit  <= ack_bit_nxt;
      intr_o   <= intr_nxt;
      wb_ack_o <= ack_set;
      bus_busy <= wb_stb_i & wb_cyc_i & (bus_busy | ack_set);
      if (ack_set) wb_dat_o <= rd_data;
      vec_o    <= vec_nxt;
      inta_q   <= inta_i;
      state    <= state_nxt;
    end
  end

endmodule

// File: tb/tb_wb_pic.sv
// Directed self-checking bench for wb_pic; a second instance with VEC_BASE=8'hFC checks vector wrap.
module tb_wb_pic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wb_dat_i;
  logic        wb_adr_i, wb_we_i, wb_stb_i, wb_cyc_i;
  logic [1:0]  wb_sel_i;
  logic [7:0]  irq_i;
  logic        inta_i;

  logic [15:0] wb_dat_o, wb_dat_o_fc;
  logic        wb_ack_o, wb_ack_o_fc;
  logic        intr_o, intr_o_fc;
  logic [7:0]  vec_o, vec_o_fc;

  int checks = 0;
  int errors = 0;
  logic [15:0] rd;
  int acks;

  always #5 clk = ~clk;

  wb_pic dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .irq_i(irq_i), .intr_o(intr_o),
    .inta_i(inta_i), .vec_o(vec_o)
  );

  wb_pic #(.VEC_BASE(8'hFC)) dut_fc (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o_fc),
    .wb_adr_i(wb_adr_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o_fc), .irq_i(irq_i), .intr_o(intr_o_fc),
    .inta_i(inta_i), .vec_o(vec_o_fc)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic adr, input logic [15:0] dat, output logic [15:0] data);
    bit got_ack = 1'b0;
    data     = 16'hxxxx;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = 2'b01;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (wb_ack_o) begin
        got_ack = 1'b1;
        data    = wb_dat_o;
        break;
      end
    end
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!got_ack) check("ack_timeout", 16'h0, 16'h1);
    tick(1);
  endtask

  task automatic wr(input logic adr, input logic [15:0] dat);
    logic [15:0] dummy;
    bus(1'b1, adr, dat, dummy);
  endtask

  task automatic rd_reg(input logic adr, output logic [15:0] data);
    bus(1'b0, adr, 16'h0000, data);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq_i = m;
    tick(2);
    irq_i = 8'h00;
    tick(4);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; wb_dat_i = '0; wb_adr_i = 1'b0; wb_we_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_sel_i = 2'b00; irq_i = 8'h00; inta_i = 1'b0;
    tick(3);
    check("rst_intr", {15'd0, intr_o}, 16'h0);
    check("rst_ack", {15'd0, wb_ack_o}, 16'h0);
    check("rst_vec", {8'd0, vec_o}, 16'h0);
    check("rst_dat", wb_dat_o, 16'h0);
    rst_n = 1'b1;
    tick(1);
    rd_reg(1'b1, rd); check("rst_imr", rd, 16'h00FF);
    rd_reg(1'b0, rd); check("rst_isr_irr", rd, 16'h0000);

    // Single-cycle ack while the strobe stays high.
    wb_adr_i = 1'b1; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1; acks = 0;
    for (int i = 0; i < 6; i++) begin tick(1); if (wb_ack_o) acks++; end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; tick(1);
    check("ack_once", 16'(acks), 16'd1);

    // Basic request and acknowledge of irq 0.
    wr(1'b1, 16'h00FE);
    rd_reg(1'b1, rd); check("imr_fe", rd, 16'h00FE);
    irq_i = 8'h01;
    for (int i = 0; i < 4; i++) begin tick(1); if (intr_o) break; end
    irq_i = 8'h00;
    check("irq0_intr", {15'd0, intr_o}, 16'h1);
    inta_i = 1'b1; tick(1);
    check("irq0_vec", {8'd0, vec_o}, 16'h0008);
    tick(1);
    check("irq0_intr_drop", {15'd0, intr_o}, 16'h0);
    rd_reg(1'b0, rd); check("irq0_isr", rd, 16'h0100);
    inta_i = 1'b0; tick(1);
    check("irq0_vec_clear", {8'd0, vec_o}, 16'h0);
    wr(1'b0, 16'h0020);
    rd_reg(1'b0, rd); check("irq0_eoi", rd, 16'h0000);

    // Two simultaneous requests: priority and EOI.
    reset_dut();
    wr(1'b1, 16'h0000);
    pulse_irq(8'h0A);
    rd_reg(1'b0, rd); check("two_irr", rd, 16'h000A);
    check("two_intr", {15'd0, intr_o}, 16'h1);
    inta_i = 1'b1; tick(1);
    check("two_vec1", {8'd0, vec_o}, 16'h0009);
    tick(1); inta_i = 1'b0; tick(2);
`ifdef PIC_AUTO_EOI_EN
    check("two_intr_mid", {15'd0, intr_o}, 16'h1);
    rd_reg(1'b0, rd); check("two_regs_mid", rd, 16'h0008);
`else
    check("two_intr_mid", {15'd0, intr_o}, 16'h0);
    rd_reg(1'b0, rd); check("two_regs_mid", rd, 16'h0208);
`endif
    wr(1'b0, 16'h0020);
    tick(1);
    check("two_intr_after_eoi", {15'd0, intr_o}, 16'h1);
    inta_i = 1'b1; tick(1);
    check("two_vec2", {8'd0, vec_o}, 16'h000B);
    tick(1); inta_i = 1'b0; tick(1);

    // Nesting: irq 2 in service blocks irq 5 but not irq 0.
    reset_dut();
    wr(1'b1, 16'h0000);
    pulse_irq(8'h04);
    inta_i = 1'b1; tick(1);
    check("nest_vec", {8'd0, vec_o}, 16'h000A);
    tick(1);
    pulse_irq(8'h20);
    check("nest_low_blocked", {15'd0, intr_o}, 16'h0);
    rd_reg(1'b0, rd); check("nest_regs", rd, 16'h0420);
    pulse_irq(8'h01);
    check("nest_high_intr", {15'd0, intr_o}, 16'h1);
    inta_i = 1'b0; tick(1);

    // EOI with nothing in service, then masking a pending request.
    reset_dut();
    wr(1'b1, 16'h0000);
    pulse_irq(8'h10);
    wr(1'b0, 16'h0020);
    rd_reg(1'b0, rd); check("eoi_empty", rd, 16'h0010);
    check("mask_pre_intr", {15'd0, intr_o}, 16'h1);
    wr(1'b1, 16'h0010);
    check("mask_intr", {15'd0, intr_o}, 16'h0);
    rd_reg(1'b0, rd); check("mask_irr_kept", rd, 16'h0010);

    // Spurious acknowledge and vector wrap.
    reset_dut();
    wr(1'b1, 16'h0000);
    inta_i = 1'b1; tick(1);
    check("spur_vec", {8'd0, vec_o}, 16'h000F);
    check("spur_vec_fc", {8'd0, vec_o_fc}, 16'h0003);
    tick(1); inta_i = 1'b0; tick(1);
    rd_reg(1'b0, rd); check("spur_regs", rd, 16'h0000);
    pulse_irq(8'h80);
    inta_i = 1'b1; tick(1);
    check("irq7_vec", {8'd0, vec_o}, 16'h000F);
    check("irq7_vec_fc", {8'd0, vec_o_fc}, 16'h0003);
    rd_reg(1'b0, rd); check("irq7_isr", rd, 16'h8000);
    inta_i = 1'b0; tick(1);

    // Reset during HOLD with inta_i held high.
    reset_dut();
    wr(1'b1, 16'h0000);
    pulse_irq(8'h02);
    inta_i = 1'b1; tick(1);
    check("hold_vec", {8'd0, vec_o}, 16'h0009);
    tick(1);
    rst_n = 1'b0; tick(1);
    check("hold_rst_vec", {8'd0, vec_o}, 16'h0);
    rst_n = 1'b1; tick(2);
    rd_reg(1'b1, rd); check("hold_rst_imr", rd, 16'h00FF);
    wr(1'b1, 16'h0000);
    pulse_irq(8'h02);
    rd_reg(1'b0, rd); check("hold_no_ack", rd, 16'h0002);
    check("hold_vec_idle", {8'd0, vec_o}, 16'h0);
    inta_i = 1'b0; tick(1);

    // ISR after acknowledge and release of irq 2, without any EOI write.
    reset_dut();
    wr(1'b1, 16'h0000);
    pulse_irq(8'h04);
    inta_i = 1'b1; tick(1);
    check("rel_vec", {8'd0, vec_o}, 16'h000A);
    tick(1); inta_i = 1'b0; tick(1);
    rd_reg(1'b0, rd);
`ifdef PIC_AUTO_EOI_EN
    check("rel_isr", rd, 16'h0000);
`else
    check("rel_isr", rd, 16'h0400);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
